esm_issue_window: RTL and testbench

- Parametrised successor to the single-index ESM dependency/issue core.
- Holds up to BS decoded instructions in a window and tracks RAW dependencies per entry against in-flight producers.
- Issues one ready instruction per cycle over a valid/ready handshake, and frees entries on completion writeback.
- Sits between fetch/decode and the execution units; adds handshakes, completion tracking, flush and occupancy reporting.

---
 rtl/esm_issue_window_if.sv | 38 +++
 rtl/esm_issue_window.sv | 139 +++++++++++++
 tb/tb_esm_issue_window.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/esm_issue_window_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// esm_issue_window_if : allocate / issue / complete / flush bundle  | rev 1.0
// ---------------------------------------------------------------------------
interface esm_issue_window_if #(
    parameter int IW = 32,
    parameter int BS = 16
);
    localparam int XW = $clog2(BS);

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] instr_in;
    logic          alu_src;
    logic          reg_write;
    logic [XW-1:0] alloc_index;
    logic          issue_valid;
    logic          issue_ready;
    logic [XW-1:0] issue_index;
    logic [IW-1:0] issue_instr;
    logic          complete_valid;
    logic [XW-1:0] complete_index;
    logic          flush;
    logic [XW:0]   occupancy;

    modport master (
        output in_valid, instr_in, alu_src, reg_write, issue_ready,
               complete_valid, complete_index, flush,
        input  in_ready, alloc_index, issue_valid, issue_index, issue_instr, occupancy
    );

    modport slave (
        input  in_valid, instr_in, alu_src, reg_write, issue_ready,
               complete_valid, complete_index, flush,
        output in_ready, alloc_index, issue_valid, issue_index, issue_instr, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/esm_issue_window.sv
`default_nettype none
// ---------------------------------------------------------------------------
// esm_issue_window : BS-entry window with RAW tracking and in-order-free issue | rev 1.0
// ---------------------------------------------------------------------------
module esm_issue_window #(
    parameter int IW     = 32,
    parameter int REGNUM = 32,
    parameter int BS     = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    esm_issue_window_if.slave    bus
);
    localparam int RW = $clog2(REGNUM);
    localparam int XW = $clog2(BS);

    logic [BS-1:0] r_valid;
    logic [BS-1:0] r_issued;
    logic [BS-1:0] r_writes;
    logic [IW-1:0] r_instr [BS];
    logic [RW-1:0] r_rd    [BS];
    logic [BS-1:0] r_dep   [BS];
    logic          r_lock;
    logic [XW-1:0] r_sel;
    logic [XW:0]   r_occ;

    logic          w_any_free;
    logic [XW-1:0] w_alloc_idx;
    logic [BS-1:0] w_ready;
    logic          w_any_ready;
    logic [XW-1:0] w_ready_idx;
    logic          w_issue_valid;
    logic [XW-1:0] w_issue_idx;
    logic          w_alloc_fire;
    logic          w_issue_fire;
    logic          w_cmp_fire;
    logic [BS-1:0] w_cmp_mask;
    logic [BS-1:0] w_new_dep;
    logic [RW-1:0] w_rs1;
    logic [RW-1:0] w_rs2;
    logic [RW-1:0] w_rd;

    assign w_rs1 = bus.instr_in[15 +: RW];
    assign w_rs2 = bus.instr_in[20 +: RW];
    assign w_rd  = bus.instr_in[7  +: RW];

    always_comb begin
        w_any_free  = 1'b0;
        w_alloc_idx = '0;
        w_any_ready = 1'b0;
        w_ready_idx = '0;
        w_ready     = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            w_ready[i] = r_valid[i] & ~r_issued[i] & (r_dep[i] == '0);
            if (!r_valid[i]) begin
                w_any_free  = 1'b1;
                w_alloc_idx = XW'(i);
            end
            if (w_ready[i]) begin
                w_any_ready = 1'b1;
                w_ready_idx = XW'(i);
            end
        end
    end

    // A locked offer is held regardless of newly ready lower slots.
    assign w_issue_valid = r_lock | w_any_ready;
    assign w_issue_idx   = r_lock ? r_sel : w_ready_idx;
    assign w_issue_fire  = w_issue_valid & bus.issue_ready;
    assign w_alloc_fire  = bus.in_valid & w_any_free;
    assign w_cmp_fire    = bus.complete_valid & r_valid[bus.complete_index]
                         & r_issued[bus.complete_index];
    assign w_cmp_mask    = w_cmp_fire ? (BS'(1) << bus.complete_index) : '0;

    // r_writes already excludes rd==0, so x0 can never match as a producer.
    always_comb begin
        w_new_dep = '0;
        for (int j = 0; j < BS; j++) begin
            w_new_dep[j] = r_valid[j] & r_writes[j] & ~w_cmp_mask[j]
                         & ((r_rd[j] == w_rs1) | (~bus.alu_src & (r_rd[j] == w_rs2)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= '0;
            r_issued <= '0;
            r_writes <= '0;
            r_lock   <= 1'b0;
            r_sel    <= '0;
            r_occ    <= '0;
            for (int i = 0; i < BS; i++) begin
                r_instr[i] <= '0;
                r_rd[i]    <= '0;
                r_dep[i]   <= '0;
            end
        end else if (bus.flush) begin
            r_valid  <= '0;
            r_issued <= '0;
            r_lock   <= 1'b0;
            r_occ    <= '0;
            for (int i = 0; i < BS; i++) begin
                r_dep[i] <= '0;
            end
        end else begin
            if (w_issue_fire) begin
                r_issued[w_issue_idx] <= 1'b1;
                r_lock                <= 1'b0;
            end else if (w_issue_valid) begin
                r_lock <= 1'b1;
                r_sel  <= w_issue_idx;
            end
            if (w_cmp_fire) begin
                r_valid[bus.complete_index]  <= 1'b0;
                r_issued[bus.complete_index] <= 1'b0;
            end
            for (int i = 0; i < BS; i++) begin
                r_dep[i] <= r_dep[i] & ~w_cmp_mask;
            end
            if (w_alloc_fire) begin
                r_valid[w_alloc_idx]  <= 1'b1;
                r_issued[w_alloc_idx] <= 1'b0;
                r_instr[w_alloc_idx]  <= bus.instr_in;
                r_writes[w_alloc_idx] <= bus.reg_write & (w_rd != '0);
                r_rd[w_alloc_idx]     <= w_rd;
                r_dep[w_alloc_idx]    <= w_new_dep;
            end
            r_occ <= r_occ + (XW+1)'(w_alloc_fire) - (XW+1)'(w_cmp_fire);
        end
    end

    assign bus.in_ready    = w_any_free;
    assign bus.alloc_index = w_alloc_idx;
    assign bus.issue_valid = w_issue_valid;
    assign bus.issue_index = w_issue_valid ? w_issue_idx : '0;
    assign bus.issue_instr = w_issue_valid ? r_instr[w_issue_idx] : '0;
    assign bus.occupancy   = r_occ;
endmodule
`default_nettype wire

// File: tb/tb_esm_issue_window.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_esm_issue_window : scoreboard bench with behavioural window model | rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_esm_issue_window;
    localparam int IW = 32, REGNUM = 32, BS = 16, XW = $clog2(BS);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    esm_issue_window_if #(.IW(IW), .BS(BS)) bus ();
    esm_issue_window #(.IW(IW), .REGNUM(REGNUM), .BS(BS)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit            in_ready;
        int            alloc;
        int            occ;
        bit            iv;
        int            idx;
        logic [IW-1:0] instr;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: a table of entries, each with the set of slots it waits on.
    bit            m_valid  [BS];
    bit            m_issued [BS];
    bit            m_writes [BS];
    int            m_rd     [BS];
    logic [IW-1:0] m_instr  [BS];
    bit [BS-1:0]   m_wait   [BS];
    bit            m_locked;
    int            m_lock_idx;

    logic          d_iv, d_alu, d_rw, d_ir, d_cv, d_fl;
    logic [IW-1:0] d_ins;
    logic [XW-1:0] d_ci;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] mk(input int rd, input int rs1, input int rs2);
        logic [IW-1:0] w;
        w        = IW'($urandom);
        w[11:7]  = 5'(rd);
        w[19:15] = 5'(rs1);
        w[24:20] = 5'(rs2);
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BS; i++) begin
            m_valid[i] = 0; m_issued[i] = 0; m_wait[i] = '0;
        end
        m_locked = 0;
        m_lock_idx = 0;
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.in_ready = 0; e.alloc = 0; e.occ = 0; e.iv = 0; e.idx = 0; e.instr = '0;
        for (int i = BS - 1; i >= 0; i--)
            if (!m_valid[i]) begin e.in_ready = 1; e.alloc = i; end
        for (int i = 0; i < BS; i++)
            if (m_valid[i]) e.occ++;
        if (m_locked) begin
            e.iv = 1; e.idx = m_lock_idx;
        end else begin
            for (int i = BS - 1; i >= 0; i--)
                if (m_valid[i] && !m_issued[i] && m_wait[i] == '0) begin e.iv = 1; e.idx = i; end
        end
        if (e.iv) e.instr = m_instr[e.idx];
        return e;
    endfunction

    task automatic model_step(input exp_t e);
        bit          cmp;
        bit [BS-1:0] nw;
        int          rs1, rs2;
        if (d_fl) begin
            model_reset();
            return;
        end
        cmp = d_cv && m_valid[d_ci] && m_issued[d_ci];
        rs1 = int'(d_ins[19:15]);
        rs2 = int'(d_ins[24:20]);
        nw  = '0;
        for (int j = 0; j < BS; j++)
            if (m_valid[j] && m_writes[j] && !(cmp && j == int'(d_ci)) &&
                (m_rd[j] == rs1 || (!d_alu && m_rd[j] == rs2)))
                nw[j] = 1;
        if (e.iv && d_ir) begin
            m_issued[e.idx] = 1; m_locked = 0;
        end else if (e.iv) begin
            m_locked = 1; m_lock_idx = e.idx;
        end
        if (cmp) begin
            m_valid[d_ci] = 0; m_issued[d_ci] = 0;
            for (int i = 0; i < BS; i++) m_wait[i][d_ci] = 0;
        end
        if (d_iv && e.in_ready) begin
            m_valid[e.alloc]  = 1;
            m_issued[e.alloc] = 0;
            m_instr[e.alloc]  = d_ins;
            m_rd[e.alloc]     = int'(d_ins[11:7]);
            m_writes[e.alloc] = d_rw && d_ins[11:7] != 0;
            m_wait[e.alloc]   = nw;
        end
    endtask

    task automatic apply();
        bus.in_valid = d_iv; bus.instr_in = d_ins; bus.alu_src = d_alu; bus.reg_write = d_rw;
        bus.issue_ready = d_ir; bus.complete_valid = d_cv; bus.complete_index = d_ci; bus.flush = d_fl;
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        apply();
        e = model_expect();
        sbq.push_back(e);
        @(posedge clk);
        model_step(e);
    endtask

    task automatic idle();
        d_iv = 0; d_ins = '0; d_alu = 0; d_rw = 1; d_ir = 1; d_cv = 0; d_ci = '0; d_fl = 0;
    endtask

    task automatic put(input int rd, input int rs1, input int rs2, input bit alu, input bit rw);
        d_iv = 1; d_ins = mk(rd, rs1, rs2); d_alu = alu; d_rw = rw;
    endtask

    task automatic do_flush();
        idle(); d_fl = 1; step(); d_fl = 0;
    endtask

    task automatic do_complete(input int k);
        d_cv = 1; d_ci = XW'(k); step(); d_cv = 0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_issue_index", 64'(bus.issue_index), 64'd0);
        chk("rst_issue_instr", 64'(bus.issue_instr), 64'd0);
        model_reset();
        sbq.delete();
        idle();
        apply();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: pops one expectation per driven cycle and compares the DUT outputs.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("in_ready", 64'(bus.in_ready), 64'(e.in_ready));
                if (e.in_ready) chk("alloc_index", 64'(bus.alloc_index), 64'(e.alloc));
                chk("occupancy", 64'(bus.occupancy), 64'(e.occ));
                chk("issue_valid", 64'(bus.issue_valid), 64'(e.iv));
                if (e.iv) begin
                    chk("issue_index", 64'(bus.issue_index), 64'(e.idx));
                    chk("issue_instr", 64'(bus.issue_instr), 64'(e.instr));
                end
            end
        end
    end

    initial begin : driver
        int iss[$];
        idle();
        apply();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        step();
        // independent stream
        put(1, 2, 3, 0, 1); step();
        put(4, 5, 6, 0, 1); step();
        d_iv = 0; step(); step();
        do_complete(0); do_complete(1);

        // RAW stall through rs2, then the same pair with an immediate operand
        for (int pass = 0; pass < 2; pass++) begin
            do_flush();
            d_ir = 0; put(5, 1, 2, 0, 1); step();
            d_iv = 0; step();
            put(9, 3, 5, pass[0], 1); step();
            d_iv = 0; d_ir = 1; step();
            repeat (4) step();
            do_complete(0);
            step(); step();
        end

        // rd=x0 producer and reg_write=0 producer
        do_flush();
        put(0, 1, 2, 0, 1); step();
        put(9, 0, 0, 0, 1); step();
        put(7, 1, 2, 0, 0); step();
        put(3, 7, 7, 0, 1); step();
        d_iv = 0; repeat (3) step();

        // full window, completion frees slot 7, alloc+complete keeps occupancy
        do_flush();
        d_ir = 0;
        for (int i = 0; i < BS; i++) begin put(i % 8, 1, 2, 0, 0); step(); end
        d_iv = 0; step();
        d_ir = 1; repeat (9) step();
        d_ir = 0; do_complete(7);
        step();
        put(2, 3, 4, 0, 1); d_cv = 1; d_ci = XW'(3); step();
        d_iv = 0; d_cv = 0; step(); step();

        // issue stability while a lower slot becomes ready, then flush
        do_flush();
        put(5, 1, 2, 0, 1); step();
        d_iv = 0; step();
        d_ir = 0; put(6, 5, 1, 0, 1); step();
        put(8, 1, 2, 0, 1); step();
        d_iv = 0; step();
        do_complete(0);
        repeat (3) step();
        put(4, 1, 2, 0, 1); d_ir = 1; d_cv = 1; d_ci = XW'(1); d_fl = 1; step();
        idle(); step();
        do_complete(2);
        step();

        // asynchronous reset in the middle of a busy window
        d_ir = 0;
        for (int i = 0; i < 5; i++) begin put(i + 1, 1, 2, 0, 1); step(); end
        d_iv = 0;
        async_reset();
        put(3, 1, 2, 0, 1); step();
        idle(); step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            d_iv  = ($urandom % 100) < 60;
            d_ins = mk($urandom % 8, $urandom % 8, $urandom % 8);
            d_alu = ($urandom % 4) == 0;
            d_rw  = ($urandom % 8) != 0;
            d_ir  = ($urandom % 100) < 70;
            d_cv  = ($urandom % 100) < 45;
            d_fl  = ($urandom % 250) == 0;
            iss.delete();
            for (int i = 0; i < BS; i++) if (m_valid[i] && m_issued[i]) iss.push_back(i);
            if (iss.size() > 0 && ($urandom % 10) < 8) d_ci = XW'(iss[$urandom % iss.size()]);
            else d_ci = XW'($urandom % BS);
            step();
        end

        idle();
        apply();
        repeat (2) @(negedge clk);
        #2;
        chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
